// File: rtl/onepulser_pkg.sv
// Shared types and helpers for the multi-channel push-button one-pulser.
//
// Contents:
//   op_state_e : per-channel FSM state (IDLE, FIRE, HOLD; code 2'd3 unused)
//   cnt_width  : width of a counter that must hold max(a, b)
package onepulser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } op_state_e;

  // Bits needed to represent values 0..max(a, b) inclusive.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/onepulser_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and IDLE/FIRE/HOLD
// one-pulser FSM, plus an auto-repeat counter when ONEPULSER_AUTOREPEAT_EN
// is defined.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   btn_in    : raw asynchronous button level, active-high
//   pulse_out : one-cycle pulse per debounced press (and per repeat)
//   held      : 1 while the FSM is in FIRE or HOLD
//
// Build option: ONEPULSER_AUTOREPEAT_EN enables periodic pulses in HOLD.
module onepulser_channel
  import onepulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out,
  output logic held
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES, 0);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  op_state_e       state_q, state_d;
  logic            pulse_q, pulse_d;
  logic            held_q, held_d;
  logic            rpt_hit;

  // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q + 1'b1 == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q) state_d = FIRE;
      FIRE:    state_d = HOLD;
      HOLD:    if (!level_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ONEPULSER_AUTOREPEAT_EN
  localparam int RPT_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;

  // rpt_cnt counts HOLD cycles since entry (or since the last repeat);
  // rpt_first selects the initial delay versus the steady period. A hit is
  // suppressed when the debounced level is falling on the same edge, so the
  // HOLD exit cycle never pulses.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_hit     = 1'b0;
    if (state_q == FIRE) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == HOLD && level_q) begin
      if (rpt_cnt_q + 1'b1 == (rpt_first_q ? RPT_DELAY_C : RPT_PERIOD_C)) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
        rpt_hit     = level_d;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign rpt_hit        = 1'b0;
`endif

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    held_d  = (state_d == FIRE) || (state_d == HOLD);
    pulse_d = (state_d == FIRE) || rpt_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      pulse_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      held_q   <= held_d;
    end
  end

  assign pulse_out = pulse_q;
  assign held      = held_q;

endmodule

// File: rtl/multi_onepulser.sv
// N-channel push-button conditioner. Each channel is an independent
// onepulser_channel; this level only adds the any_pulse OR-reduction.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   btn_in    : raw button levels [CHANNELS-1:0]
//   pulse_out : per-channel one-cycle press pulses
//   held      : per-channel FIRE/HOLD status
//   any_pulse : combinational OR of pulse_out
//
// Build option: ONEPULSER_AUTOREPEAT_EN (handled inside onepulser_channel).
module multi_onepulser
  import onepulser_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] held,
  output logic                any_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    onepulser_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in[i]),
      .pulse_out(pulse_out[i]),
      .held     (held[i])
    );
  end

  assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_multi_onepulser.sv
module tb_multi_onepulser;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] pulse_out;
  logic [3:0] held;
  logic       any_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_onepulser #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .pulse_out(pulse_out),
    .held     (held),
    .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  // One active edge, then settle to the following falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 4'b0000;
    tick(); tick(); tick();
    tests_run++;
    if ({pulse_out, held, any_pulse} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: pulse=%b held=%b any=%b, want all 0", pulse_out, held, any_pulse);
    end
    rst = 1'b0;
    tick(); tick();
    tests_run++;
    if ({pulse_out, held, any_pulse} !== 9'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: pulse=%b held=%b any=%b, want all 0", pulse_out, held, any_pulse);
    end
  endtask

  task automatic test_single_press();
    logic [3:0] exp_p, exp_h;
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_p = (t == 7) ? 4'b0001 : 4'b0000;
      exp_h = (t >= 7) ? 4'b0001 : 4'b0000;
      tests_run++;
      if ({pulse_out, held} !== {exp_p, exp_h}) begin
        tests_failed++;
        $display("FAIL single_press t=%0d: pulse=%b held=%b, want pulse=%b held=%b", t, pulse_out, held, exp_p, exp_h);
      end
    end
    btn_in[0] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_h = (t < 7) ? 4'b0001 : 4'b0000;
      tests_run++;
      if ({pulse_out, held} !== {4'b0000, exp_h}) begin
        tests_failed++;
        $display("FAIL release t=%0d: pulse=%b held=%b, want pulse=0000 held=%b", t, pulse_out, held, exp_h);
      end
    end
  endtask

  task automatic test_glitch();
    btn_in[1] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) btn_in[1] = 1'b0;
      tests_run++;
      if (pulse_out[1] !== 1'b0 || held[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch t=%0d: pulse1=%b held1=%b, want 0 0", t, pulse_out[1], held[1]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_p;
    btn_in = 4'b1001;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_p = (t == 7) ? 4'b1001 : 4'b0000;
      tests_run++;
      if (pulse_out !== exp_p || any_pulse !== (t == 7)) begin
        tests_failed++;
        $display("FAIL simultaneous t=%0d: pulse=%b any=%b, want pulse=%b any=%b", t, pulse_out, any_pulse, exp_p, (t == 7));
      end
    end
    btn_in = 4'b0000;
    for (int t = 1; t <= 10; t++) tick();
    tests_run++;
    if (held !== 4'b0000) begin
      tests_failed++;
      $display("FAIL simultaneous_release: held=%b, want 0000", held);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] exp_p, exp_h;
    btn_in[2] = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    tests_run++;
    if (held !== 4'b0100) begin
      tests_failed++;
      $display("FAIL pre_reset_hold: held=%b, want 0100", held);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({pulse_out, held, any_pulse} !== 9'b0) begin
      tests_failed++;
      $display("FAIL async_reset: pulse=%b held=%b any=%b, want all 0", pulse_out, held, any_pulse);
    end
    tick(); tick();
    tests_run++;
    if ({pulse_out, held} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_held: pulse=%b held=%b, want 0", pulse_out, held);
    end
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_p = (t == 7) ? 4'b0100 : 4'b0000;
      exp_h = (t >= 7) ? 4'b0100 : 4'b0000;
      tests_run++;
      if ({pulse_out, held} !== {exp_p, exp_h}) begin
        tests_failed++;
        $display("FAIL post_reset t=%0d: pulse=%b held=%b, want pulse=%b held=%b", t, pulse_out, held, exp_p, exp_h);
      end
    end
    btn_in[2] = 1'b0;
    for (int t = 1; t <= 10; t++) tick();
  endtask

  task automatic test_back_to_back();
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 7; t++) tick();
    tests_run++;
    if (pulse_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL b2b_first_pulse: pulse=%b, want 0001", pulse_out);
    end
    tick(); tick(); tick();
    btn_in[0] = 1'b0;
    for (int t = 1; t <= 6; t++) tick();
    tests_run++;
    if (held[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_still_held: held0=%b, want 1", held[0]);
    end
    btn_in[0] = 1'b1;
    tick();
    tests_run++;
    if (held[0] !== 1'b0 || pulse_out[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: held0=%b pulse0=%b, want 0 0", held[0], pulse_out[0]);
    end
    for (int t = 2; t <= 8; t++) begin
      tick();
      tests_run++;
      if (pulse_out[0] !== (t == 7)) begin
        tests_failed++;
        $display("FAIL b2b_second t=%0d: pulse0=%b, want %b", t, pulse_out[0], (t == 7));
      end
    end
    btn_in[0] = 1'b0;
    for (int t = 1; t <= 10; t++) tick();
  endtask

`ifdef ONEPULSER_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic exp;
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 7; t++) tick();
    tests_run++;
    if (pulse_out[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rpt_fire: pulse0=%b, want 1", pulse_out[0]);
    end
    for (int k = 0; k <= 50; k++) begin
      tick();
      exp = (k >= 16) && (((k - 16) % 8) == 0);
      tests_run++;
      if (pulse_out[0] !== exp) begin
        tests_failed++;
        $display("FAIL rpt_hold k=%0d: pulse0=%b, want %b", k, pulse_out[0], exp);
      end
    end
    btn_in[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      tests_run++;
      if (pulse_out[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rpt_release t=%0d: pulse0=%b, want 0", t, pulse_out[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    test_back_to_back();
`ifdef ONEPULSER_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
